// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the ping-pong ball block: scoring, serve delay, update rate, winner.
// Optional pause input is enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned SPEED_DIV    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       left_scored,
    input  logic       right_scored,
    output logic       ball_reset,
    output logic       ball_update,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       serving,
    output logic       game_over,
    output logic       left_won
`ifdef PONG_PAUSE_EN
    ,
    input  logic       pause
`endif
);

    localparam int unsigned CW = $clog2(SERVE_FRAMES + 1);
    localparam int unsigned DW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int unsigned SW = 4;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SERVE     = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] POINT     = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;

    logic [2:0]    state, state_next;
    logic [CW-1:0] serve_cnt, serve_cnt_next;
    logic [DW-1:0] div_cnt, div_cnt_next;
    logic [SW-1:0] left_score_next, right_score_next;
    logic          point_left, point_left_next;
    logic          left_won_next;
    logic          ball_update_next;
    logic          tick;

    // A paused frame simply never reaches the counters
`ifdef PONG_PAUSE_EN
    assign tick = frame_tick & ~pause;
`else
    assign tick = frame_tick;
`endif

    // State, counters and all outputs; outputs follow the state being entered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            serve_cnt   <= '0;
            div_cnt     <= '0;
            point_left  <= 1'b0;
            left_score  <= '0;
            right_score <= '0;
            left_won    <= 1'b0;
            ball_reset  <= 1'b1;
            ball_update <= 1'b0;
            serving     <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_next;
            serve_cnt   <= serve_cnt_next;
            div_cnt     <= div_cnt_next;
            point_left  <= point_left_next;
            left_score  <= left_score_next;
            right_score <= right_score_next;
            left_won    <= left_won_next;
            ball_reset  <= (state_next != PLAY);
            ball_update <= ball_update_next;
            serving     <= (state_next == SERVE);
            game_over   <= (state_next == GAME_OVER);
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_next       = state;
        serve_cnt_next   = serve_cnt;
        div_cnt_next     = div_cnt;
        point_left_next  = point_left;
        left_score_next  = left_score;
        right_score_next = right_score;
        left_won_next    = left_won;
        ball_update_next = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next       = SERVE;
                    left_score_next  = '0;
                    right_score_next = '0;
                    serve_cnt_next   = CW'(SERVE_FRAMES);
                end
            end
            SERVE: begin
                if (tick) begin
                    if (serve_cnt == CW'(1)) begin
                        state_next   = PLAY;
                        div_cnt_next = '0;
                    end else begin
                        serve_cnt_next = serve_cnt - CW'(1);
                    end
                end
            end
            PLAY: begin
                // A scoring cycle suppresses any update pulse; left wins a tie
                if (left_scored) begin
                    left_score_next = left_score + SW'(1);
                    point_left_next = 1'b1;
                    state_next      = POINT;
                end else if (right_scored) begin
                    right_score_next = right_score + SW'(1);
                    point_left_next  = 1'b0;
                    state_next       = POINT;
                end else if (tick) begin
                    if (div_cnt == DW'(SPEED_DIV - 1)) begin
                        div_cnt_next     = '0;
                        ball_update_next = 1'b1;
                    end else begin
                        div_cnt_next = div_cnt + DW'(1);
                    end
                end
            end
            POINT: begin
                if ((point_left ? left_score : right_score) == SW'(WIN_SCORE)) begin
                    state_next    = GAME_OVER;
                    left_won_next = point_left;
                end else begin
                    state_next     = SERVE;
                    serve_cnt_next = CW'(SERVE_FRAMES);
                end
            end
            GAME_OVER: begin
                if (start) begin
                    state_next       = SERVE;
                    left_score_next  = '0;
                    right_score_next = '0;
                    left_won_next    = 1'b0;
                    serve_cnt_next   = CW'(SERVE_FRAMES);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
